// File: rtl/video_timing_pkg.sv
// Shared 800x600@72Hz raster timing and beam coordinate type, used by the
// timing generator, background, sprites and mixer.
package video_timing_pkg;

  typedef logic signed [10:0] coord_t;

  localparam int HACTIVE  = 800;
  localparam int HFP      = 56;
  localparam int HSYNC    = 120;
  localparam int HBP      = 64;
  localparam int VACTIVE  = 600;
  localparam int VFP      = 37;
  localparam int VSYNC    = 6;
  localparam int VBP      = 23;
  localparam bit HSYNC_POL = 1'b1;
  localparam bit VSYNC_POL = 1'b1;
  localparam int PIPE_DLY = 1;

  // Undelayed raster terms, all active-high before polarity is applied.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
  } sync_t;

endpackage

// File: rtl/video_timing_if.sv
// Beam position and sync bundle from the timing generator to every layer.
interface video_timing_if;
  import video_timing_pkg::coord_t;

  coord_t spotX;
  coord_t spotY;
  logic   hsync;
  logic   vsync;
  logic   blank_n;
  logic   frame_start;

  modport master (output spotX, spotY, hsync, vsync, blank_n, frame_start);
  modport slave  (input  spotX, spotY, hsync, vsync, blank_n, frame_start);

endinterface

// File: rtl/video_timing_sync_delay.sv
// Async-reset shift register with a per-bit reset value, used to align the
// raster control terms with the registered colour pipeline.
module sync_delay #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: signed beam counters with zero latency plus sync,
// blank and frame-start strobes delayed to line up with registered RGB.
module video_timing
  import video_timing_pkg::coord_t;
  import video_timing_pkg::sync_t;
#(
  parameter int HACTIVE   = video_timing_pkg::HACTIVE,
  parameter int HFP       = video_timing_pkg::HFP,
  parameter int HSYNC     = video_timing_pkg::HSYNC,
  parameter int HBP       = video_timing_pkg::HBP,
  parameter int VACTIVE   = video_timing_pkg::VACTIVE,
  parameter int VFP       = video_timing_pkg::VFP,
  parameter int VSYNC     = video_timing_pkg::VSYNC,
  parameter int VBP       = video_timing_pkg::VBP,
  parameter bit HSYNC_POL = video_timing_pkg::HSYNC_POL,
  parameter bit VSYNC_POL = video_timing_pkg::VSYNC_POL,
  parameter int PIPE_DLY  = video_timing_pkg::PIPE_DLY
) (
  input  logic           clk,
  input  logic           reset_n,
  video_timing_if.master vid
);

  // Sync sits at the most negative coordinates so that 0 is the first active pixel.
  localparam int HMIN = -(HSYNC + HBP);
  localparam int HMAX = HACTIVE + HFP - 1;
  localparam int VMIN = -(VSYNC + VBP);
  localparam int VMAX = VACTIVE + VFP - 1;

  if (HMIN < -1024 || HMAX > 1023 || VMIN < -1024 || VMAX > 1023 || PIPE_DLY < 1) begin : g_bad_timing
    $error("video_timing: raster does not fit coord_t or PIPE_DLY < 1");
  end

  localparam coord_t HMIN_C  = coord_t'(HMIN);
  localparam coord_t HMAX_C  = coord_t'(HMAX);
  localparam coord_t VMIN_C  = coord_t'(VMIN);
  localparam coord_t VMAX_C  = coord_t'(VMAX);
  localparam coord_t HS_END  = coord_t'(HMIN + HSYNC);
  localparam coord_t VS_END  = coord_t'(VMIN + VSYNC);
  localparam coord_t H_ACT   = coord_t'(HACTIVE);
  localparam coord_t V_ACT   = coord_t'(VACTIVE);
  localparam coord_t ZERO    = coord_t'(0);
  localparam coord_t ONE     = coord_t'(1);

  coord_t spotX;
  coord_t spotY;
  sync_t  raw;
  sync_t  dly;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spotX <= HMIN_C;
      spotY <= VMIN_C;
    end else if (spotX == HMAX_C) begin
      spotX <= HMIN_C;
      spotY <= (spotY == VMAX_C) ? VMIN_C : coord_t'(spotY + ONE);
    end else begin
      spotX <= coord_t'(spotX + ONE);
    end
  end

  // All operands are coord_t, so every comparison stays signed.
  always_comb begin
    raw     = '0;
    raw.hs  = spotX < HS_END;
    raw.vs  = spotY < VS_END;
    raw.act = (spotX >= ZERO) && (spotX < H_ACT) && (spotY >= ZERO) && (spotY < V_ACT);
    raw.fs  = (spotX == HMIN_C) && (spotY == VMIN_C);
  end

  sync_delay #(
    .WIDTH     ($bits(sync_t)),
    .DEPTH     (PIPE_DLY),
    .RESET_VAL ('0)
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (raw),
    .dout    (dly)
  );

  assign vid.spotX       = spotX;
  assign vid.spotY       = spotY;
  assign vid.hsync       = HSYNC_POL ? dly.hs : ~dly.hs;
  assign vid.vsync       = VSYNC_POL ? dly.vs : ~dly.vs;
  assign vid.blank_n     = dly.act;
  assign vid.frame_start = dly.fs;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a full-size instance with PIPE_DLY=1 and a shrunken
// raster with PIPE_DLY=3 and inverted hsync, both against a position model.
module tb_video_timing;

  typedef struct {
    int hact, hfp, hsw, hbp, vact, vfp, vsw, vbp, dly;
    bit hpol, vpol;
  } tim_t;

  typedef struct {
    int x, y;
    bit hs, vs, bl, fs;
  } obs_t;

  typedef struct {
    int n, x, y;
    bit hs, vs, bl, fs;
  } vec_t;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   nA, nB;
  int   errors = 0;
  int   checks = 0;
  bit   prevFsA, prevFsB, prevBlB;
  tim_t tA, tB;
  vec_t vecs[$];
  int   vi = 0;

  bit   phase1 = 1'b1;
  int   hsHighA = 0, yChangesA = 0, yChangeNA = -1, lastYA = -29;
  int   blCntB = 0, vsCntB = 0, hsLowB = 0, fsCntB = 0;
  int   originB = -1, riseB = -1;
  int   fsTimesB[$];

  always #5 clk = ~clk;

  video_timing_if ifA ();
  video_timing_if ifB ();

  video_timing u_dutA (
    .clk     (clk),
    .reset_n (rstA),
    .vid     (ifA)
  );

  video_timing #(
    .HACTIVE(16), .HFP(3), .HSYNC(4), .HBP(5),
    .VACTIVE(10), .VFP(2), .VSYNC(2), .VBP(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .PIPE_DLY(3)
  ) u_dutB (
    .clk     (clk),
    .reset_n (rstB),
    .vid     (ifB)
  );

  // Position from elapsed clocks since reset release; strobes from the
  // position PIPE_DLY clocks earlier, counted from the start of the sync.
  function automatic obs_t model(tim_t t, int n);
    obs_t o;
    int   htot, vtot, p, q, qx, qy;
    bit   hs, vs, bl, fs;
    htot = t.hsw + t.hbp + t.hact + t.hfp;
    vtot = t.vsw + t.vbp + t.vact + t.vfp;
    p = n % (htot * vtot);
    o.x = p % htot - (t.hsw + t.hbp);
    o.y = p / htot - (t.vsw + t.vbp);
    hs = 0; vs = 0; bl = 0; fs = 0;
    if (n >= t.dly) begin
      q  = (n - t.dly) % (htot * vtot);
      qx = q % htot;
      qy = q / htot;
      hs = qx < t.hsw;
      vs = qy < t.vsw;
      bl = (qx >= t.hsw + t.hbp) && (qx < t.hsw + t.hbp + t.hact) &&
           (qy >= t.vsw + t.vbp) && (qy < t.vsw + t.vbp + t.vact);
      fs = (q == 0);
    end
    o.hs = t.hpol ? hs : !hs;
    o.vs = t.vpol ? vs : !vs;
    o.bl = bl;
    o.fs = fs;
    return o;
  endfunction

  function automatic obs_t sampleA();
    obs_t o;
    o.x  = int'(ifA.spotX);
    o.y  = int'(ifA.spotY);
    o.hs = ifA.hsync;
    o.vs = ifA.vsync;
    o.bl = ifA.blank_n;
    o.fs = ifA.frame_start;
    return o;
  endfunction

  function automatic obs_t sampleB();
    obs_t o;
    o.x  = int'(ifB.spotX);
    o.y  = int'(ifB.spotY);
    o.hs = ifB.hsync;
    o.vs = ifB.vsync;
    o.bl = ifB.blank_n;
    o.fs = ifB.frame_start;
    return o;
  endfunction

  task automatic cmp(input string what, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", what, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input tim_t t, input int n,
                             input obs_t a, input bit prevFs);
    obs_t  e;
    string p;
    int    hmin, hmax, vmin, vmax;
    e = model(t, n);
    p = $sformatf("%s n=%0d", tag, n);
    hmin = -(t.hsw + t.hbp);
    hmax = t.hact + t.hfp - 1;
    vmin = -(t.vsw + t.vbp);
    vmax = t.vact + t.vfp - 1;
    cmp({p, " spotX"}, a.x, e.x);
    cmp({p, " spotY"}, a.y, e.y);
    cmp({p, " hsync"}, int'(a.hs), int'(e.hs));
    cmp({p, " vsync"}, int'(a.vs), int'(e.vs));
    cmp({p, " blank_n"}, int'(a.bl), int'(e.bl));
    cmp({p, " frame_start"}, int'(a.fs), int'(e.fs));
    cmp({p, " spotX in range"}, int'(a.x >= hmin && a.x <= hmax), 1);
    cmp({p, " spotY in range"}, int'(a.y >= vmin && a.y <= vmax), 1);
    cmp({p, " frame_start back-to-back"}, int'(prevFs && a.fs), 0);
  endtask

  task automatic sampleCheck(input bit chkA, input bit chkB);
    obs_t a, b;
    a = sampleA();
    b = sampleB();
    if (chkA) begin
      checkOutput("A", tA, nA, a, prevFsA);
      prevFsA = a.fs;
      if (rstA && vi < vecs.size() && nA == vecs[vi].n) begin
        cmp($sformatf("A vec%0d spotX", vi), a.x, vecs[vi].x);
        cmp($sformatf("A vec%0d spotY", vi), a.y, vecs[vi].y);
        cmp($sformatf("A vec%0d hsync", vi), int'(a.hs), int'(vecs[vi].hs));
        cmp($sformatf("A vec%0d vsync", vi), int'(a.vs), int'(vecs[vi].vs));
        cmp($sformatf("A vec%0d blank_n", vi), int'(a.bl), int'(vecs[vi].bl));
        cmp($sformatf("A vec%0d frame_start", vi), int'(a.fs), int'(vecs[vi].fs));
        vi++;
      end
      if (phase1 && rstA && nA >= 1 && nA <= 1040) begin
        hsHighA += int'(a.hs);
        if (a.y != lastYA) begin
          yChangesA++;
          yChangeNA = nA;
        end
      end
      lastYA = a.y;
    end
    if (chkB) begin
      checkOutput("B", tB, nB, b, prevFsB);
      prevFsB = b.fs;
      if (phase1 && rstB) begin
        if (nB >= 3 && nB < 3 + 476) begin
          blCntB += int'(b.bl);
          vsCntB += int'(b.vs);
          hsLowB += int'(!b.hs);
          fsCntB += int'(b.fs);
        end
        if (originB < 0 && b.x == 0 && b.y == 0) originB = nB;
        if (riseB < 0 && b.bl && !prevBlB) riseB = nB;
        if (b.fs) fsTimesB.push_back(nB);
      end
      prevBlB = b.bl;
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      if (rstA) nA++;
      if (rstB) nB++;
      @(negedge clk);
      sampleCheck(1'b1, 1'b1);
    end
  endtask

  // Asserts reset between clock edges and checks the outputs collapse at once.
  task automatic pulseReset(input bit doA, input bit doB, input int hold);
    if (doA) begin rstA = 1'b0; nA = 0; end
    if (doB) begin rstB = 1'b0; nB = 0; end
    #1;
    sampleCheck(doA, doB);
    applyStimulus(hold);
    rstA = 1'b1;
    rstB = 1'b1;
  endtask

  initial begin
    int found;
    int sel;
    tA = '{hact:800, hfp:56, hsw:120, hbp:64, vact:600, vfp:37, vsw:6, vbp:23,
           dly:1, hpol:1'b1, vpol:1'b1};
    tB = '{hact:16, hfp:3, hsw:4, hbp:5, vact:10, vfp:2, vsw:2, vbp:3,
           dly:3, hpol:1'b0, vpol:1'b1};

    vecs.push_back('{1,    -183, -29, 1'b1, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{2,    -182, -29, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{120,   -64, -29, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{121,   -63, -29, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1039,  855, -29, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1040, -184, -28, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1041, -183, -28, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2080, -184, -27, 1'b0, 1'b1, 1'b0, 1'b0});

    nA = 0; nB = 0;
    rstA = 1'b1; rstB = 1'b1;
    #2;
    rstA = 1'b0; rstB = 1'b0;
    repeat (5) begin
      @(negedge clk);
      sampleCheck(1'b1, 1'b1);
    end
    rstA = 1'b1;
    rstB = 1'b1;
    applyStimulus(2100);
    phase1 = 1'b0;

    cmp("A table entries reached", vi, vecs.size());
    cmp("A hsync high clocks in first line", hsHighA, 120);
    cmp("A spotY changes in first line", yChangesA, 1);
    cmp("A spotY change clock", yChangeNA, 1040);
    cmp("B blank_n clocks per frame", blCntB, 160);
    cmp("B vsync clocks per frame", vsCntB, 56);
    cmp("B hsync active-low clocks per frame", hsLowB, 68);
    cmp("B frame_start pulses per frame", fsCntB, 1);
    cmp("B origin clock", originB, 149);
    cmp("B blank_n rise after origin", riseB - originB, 3);
    cmp("B frame_start count", int'(fsTimesB.size() >= 2), 1);
    if (fsTimesB.size() >= 2) begin
      cmp("B first frame_start clock", fsTimesB[0], 3);
      cmp("B frame_start period", fsTimesB[1] - fsTimesB[0], 476);
    end

    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      if (ifB.spotX == 8 && ifB.spotY == 5) found = 1;
      else applyStimulus(1);
    end
    cmp("B reached mid-frame point", found, 1);
    pulseReset(1'b0, 1'b1, 2);
    applyStimulus(500);

    repeat (8) begin
      applyStimulus($urandom_range(20, 700));
      sel = $urandom_range(1, 3);
      pulseReset(sel[0], sel[1], $urandom_range(1, 3));
    end
    applyStimulus(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
